// File: rtl/lc3_fetch_pkg.sv
// Shared types for the fetch path: FSM state encoding, queue entry layout and
// the reset PC.
package lc3_fetch_pkg;

    parameter int PKG_DATA_W = 16;

    localparam logic [PKG_DATA_W-1:0] PC_RESET_DEF = '0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } fetch_state_t;

    typedef struct packed {
        logic [PKG_DATA_W-1:0] pc;
        logic [PKG_DATA_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding {pc, inst} pairs. Flush clears occupancy in one edge.
// The head is read straight from storage, so it holds its last value once empty.
module fetch_queue
    import lc3_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wr_entry,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Pointer wrap relies on DEPTH being a power of two.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_entry;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer for a fixed-latency instruction memory,
// feeding a prefetch queue drained by a valid/ready consumer.
//
// state | meaning
// IDLE  | no read outstanding; waits for run and queue room
// ISSUE | one-cycle read strobe at PC, loads the latency counter
// WAIT  | counts down; captures mem_rdata when the counter reaches 1
module pc_fetch_unit
    import lc3_fetch_pkg::*;
#(
    parameter int                DATA_W   = PKG_DATA_W,
    parameter logic [DATA_W-1:0] PC_RESET = DATA_W'(PC_RESET_DEF),
    parameter int                MEM_LAT  = 2,
    parameter int                FQ_DEPTH = 4,
    localparam int               CNT_W    = $clog2(FQ_DEPTH) + 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              run,
    input  logic              redirect_valid,
    input  logic [DATA_W-1:0] redirect_target,
    output logic              mem_rd_en,
    output logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [DATA_W-1:0] inst_pc,
    output logic [DATA_W-1:0] fetch_pc,
    output logic [CNT_W-1:0]  fq_count
);

    fetch_state_t      state;
    logic [DATA_W-1:0] pc;
    logic [3:0]        wait_cnt;
    logic              capture;
    logic              pop;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    fetch_entry_t      wr_entry;
    fetch_entry_t      head;

    // Sampling is purely counter-timed, so an abandoned read is never captured.
    assign capture    = (state == WAIT) && (wait_cnt == 4'd1);
    assign pop        = inst_valid && inst_ready;
    assign count_next = count + CNT_W'(capture) - CNT_W'(pop);
    assign wr_entry   = {pc, mem_rdata};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            pc       <= PC_RESET;
            wait_cnt <= '0;
        end else if (redirect_valid) begin
            state    <= IDLE;
            pc       <= redirect_target;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run && (count < CNT_W'(FQ_DEPTH))) state <= ISSUE;
                end
                ISSUE: begin
                    wait_cnt <= 4'(MEM_LAT);
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (capture) begin
                        pc    <= pc + 1'b1;
                        state <= (run && (count_next < CNT_W'(FQ_DEPTH))) ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk      (Clk),
        .rst      (Reset),
        .push     (capture && !redirect_valid),
        .pop      (pop && !redirect_valid),
        .flush    (redirect_valid),
        .wr_entry (wr_entry),
        .head     (head),
        .count    (count)
    );

    assign mem_rd_en  = (state == ISSUE) && !redirect_valid;
    assign mem_addr   = pc;
    assign inst_valid = (count != '0);
    assign inst_data  = head.inst;
    assign inst_pc    = head.pc;
    assign fetch_pc   = pc;
    assign fq_count   = count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a 2-cycle memory returning addr ^ A5A5.
module tb_pc_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        run;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_data;
    logic [15:0] inst_pc;
    logic [15:0] fetch_pc;
    logic [2:0]  fq_count;

    int checks   = 0;
    int failures = 0;
    int n;

    logic [15:0] d1;
    logic [15:0] d2;

    pc_fetch_unit #(
        .DATA_W   (16),
        .PC_RESET (16'h0000),
        .MEM_LAT  (2),
        .FQ_DEPTH (4)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .run             (run),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .mem_rd_en       (mem_rd_en),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .fetch_pc        (fetch_pc),
        .fq_count        (fq_count)
    );

    always #5 Clk = ~Clk;

    // Data is valid exactly two cycles after the strobe cycle; otherwise junk.
    always @(posedge Clk) begin
        d1 <= mem_rd_en ? (mem_addr ^ 16'hA5A5) : 16'hDEAD;
        d2 <= d1;
    end
    assign mem_rdata = d2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        Reset           = 1'b1;
        run             = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 16'h0000;
        inst_ready      = 1'b1;

        // Reset values and first streaming fetches
        tick();
        chk("rst_fetch_pc", 32'(fetch_pc), 32'h0000);
        chk("rst_fq_count", 32'(fq_count), 0);
        chk("rst_inst_valid", 32'(inst_valid), 0);
        chk("rst_mem_rd_en", 32'(mem_rd_en), 0);
        Reset = 1'b0;
        run   = 1'b1;
        tick();
        chk("s1_strobe0", 32'(mem_rd_en), 1);
        chk("s1_addr0", 32'(mem_addr), 32'h0000);
        tick();
        chk("s1_wait_rd_en", 32'(mem_rd_en), 0);
        chk("s1_wait_valid", 32'(inst_valid), 0);
        tick();
        chk("s1_wait2_rd_en", 32'(mem_rd_en), 0);
        chk("s1_wait2_valid", 32'(inst_valid), 0);
        tick();
        chk("s1_strobe1", 32'(mem_rd_en), 1);
        chk("s1_addr1", 32'(mem_addr), 32'h0001);
        chk("s1_valid0", 32'(inst_valid), 1);
        chk("s1_pc0", 32'(inst_pc), 32'h0000);
        chk("s1_data0", 32'(inst_data), 32'hA5A5);
        tick();
        tick();
        tick();
        chk("s1_strobe2", 32'(mem_rd_en), 1);
        chk("s1_addr2", 32'(mem_addr), 32'h0002);
        chk("s1_pc1", 32'(inst_pc), 32'h0001);
        chk("s1_data1", 32'(inst_data), 32'hA5A4);

        // Fill queue with consumer stalled
        run        = 1'b0;
        inst_ready = 1'b0;
        do_reset();
        run = 1'b1;
        n   = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_rd_en) begin
                chk("fill_addr", 32'(mem_addr), 32'(n));
                n++;
            end
        end
        chk("fill_strobes", 32'(n), 4);
        chk("fill_count", 32'(fq_count), 4);
        chk("fill_rd_en", 32'(mem_rd_en), 0);
        chk("fill_head_pc", 32'(inst_pc), 32'h0000);
        inst_ready = 1'b1;
        tick();
        chk("pop_count", 32'(fq_count), 3);
        chk("pop_head_pc", 32'(inst_pc), 32'h0001);
        chk("pop_head_data", 32'(inst_data), 32'hA5A4);
        inst_ready = 1'b0;
        tick();
        chk("refill_strobe", 32'(mem_rd_en), 1);
        chk("refill_addr", 32'(mem_addr), 32'h0004);

        // Redirect during WAIT with two entries queued
        run = 1'b0;
        do_reset();
        run = 1'b1;
        repeat (7) tick();
        chk("r1_strobe2", 32'(mem_rd_en), 1);
        chk("r1_addr2", 32'(mem_addr), 32'h0002);
        chk("r1_count2", 32'(fq_count), 2);
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 16'h3000;
        tick();
        chk("r1_flush_count", 32'(fq_count), 0);
        chk("r1_flush_valid", 32'(inst_valid), 0);
        chk("r1_fetch_pc", 32'(fetch_pc), 32'h3000);
        chk("r1_idle_rd_en", 32'(mem_rd_en), 0);
        redirect_valid = 1'b0;
        tick();
        chk("r1_strobe", 32'(mem_rd_en), 1);
        chk("r1_addr", 32'(mem_addr), 32'h3000);
        chk("r1_no_stale", 32'(fq_count), 0);
        repeat (3) tick();
        chk("r1_valid", 32'(inst_valid), 1);
        chk("r1_inst_pc", 32'(inst_pc), 32'h3000);
        chk("r1_inst_data", 32'(inst_data), 32'h95A5);
        chk("r1_count1", 32'(fq_count), 1);

        // Redirect in the same cycle as a capture and a pop
        tick();
        tick();
        chk("r2_pre_count", 32'(fq_count), 1);
        inst_ready      = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 16'h4000;
        tick();
        chk("r2_count", 32'(fq_count), 0);
        chk("r2_valid", 32'(inst_valid), 0);
        chk("r2_fetch_pc", 32'(fetch_pc), 32'h4000);
        redirect_valid = 1'b0;
        tick();
        chk("r2_strobe", 32'(mem_rd_en), 1);
        chk("r2_addr", 32'(mem_addr), 32'h4000);
        tick();
        tick();
        chk("r2_captured_absent", 32'(fq_count), 0);
        tick();
        chk("r2_inst_pc", 32'(inst_pc), 32'h4000);
        chk("r2_inst_data", 32'(inst_data), 32'hE5A5);

        // Redirect to FFFF, PC wraps to 0000
        redirect_valid  = 1'b1;
        redirect_target = 16'hFFFF;
        tick();
        chk("w_count", 32'(fq_count), 0);
        chk("w_fetch_pc", 32'(fetch_pc), 32'hFFFF);
        redirect_valid = 1'b0;
        tick();
        chk("w_strobe_ffff", 32'(mem_rd_en), 1);
        chk("w_addr_ffff", 32'(mem_addr), 32'hFFFF);
        repeat (3) tick();
        chk("w_pc_ffff", 32'(inst_pc), 32'hFFFF);
        chk("w_data_ffff", 32'(inst_data), 32'h5A5A);
        chk("w_addr_0000", 32'(mem_addr), 32'h0000);
        chk("w_fetch_pc0", 32'(fetch_pc), 32'h0000);
        repeat (3) tick();
        chk("w_pc_0000", 32'(inst_pc), 32'h0000);
        chk("w_data_0000", 32'(inst_data), 32'hA5A5);
        inst_ready = 1'b0;
        tick();
        chk("m_pre_count", 32'(fq_count), 1);
        chk("m_pre_fetch_pc", 32'(fetch_pc), 32'h0001);

        // Asynchronous reset mid-WAIT
        #2;
        Reset = 1'b1;
        #2;
        chk("ar_fetch_pc", 32'(fetch_pc), 32'h0000);
        chk("ar_count", 32'(fq_count), 0);
        chk("ar_valid", 32'(inst_valid), 0);
        chk("ar_rd_en", 32'(mem_rd_en), 0);
        tick();
        Reset = 1'b0;
        tick();
        chk("ar_restart_strobe", 32'(mem_rd_en), 1);
        chk("ar_restart_addr", 32'(mem_addr), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
